// File: rtl/emu_step_pkg.sv
// Shared types and default widths for the emulation step controller.
package emu_step_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2,
        HALT = 2'd3
    } step_state_t;

    localparam int DT_W_DEF   = 16;
    localparam int TIME_W_DEF = 40;
    localparam int CNT_W_DEF  = 16;

endpackage

// File: rtl/emu_time_acc.sv
// Emulated-time accumulator: adds dt on each committed step and reports whether
// the next proposed step fits below the stop time without overflowing.
module emu_time_acc
    import emu_step_pkg::*;
#(
    parameter int DT_W   = DT_W_DEF,
    parameter int TIME_W = TIME_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              add_en,
    input  logic [DT_W-1:0]   dt_in,
    input  logic              stop_en,
    input  logic [TIME_W-1:0] stop_time,
    output logic [TIME_W-1:0] emu_time,
    output logic              fits
);

    logic [TIME_W-1:0] emu_time_q;
    logic [TIME_W-1:0] emu_time_d;
    logic [TIME_W:0]   sum;

    // One extra bit so the carry-out doubles as the overflow flag.
    assign sum      = {1'b0, emu_time_q} + {{(TIME_W + 1 - DT_W){1'b0}}, dt_in};
    assign fits     = !sum[TIME_W] && !(stop_en && (sum[TIME_W-1:0] > stop_time));
    assign emu_time = emu_time_q;

    always_comb begin
        emu_time_d = emu_time_q;
        if (clr) begin
            emu_time_d = '0;
        end else if (add_en) begin
            emu_time_d = sum[TIME_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            emu_time_q <= '0;
        end else begin
            emu_time_q <= emu_time_d;
        end
    end

endmodule

// File: rtl/emu_step_ctrl.sv
// Emulation step controller: issues one registered clock-enable pulse per
// committed timestep, free-running or in bursts, with stall and stop-time halt.
module emu_step_ctrl
    import emu_step_pkg::*;
#(
    parameter int DT_W   = DT_W_DEF,
    parameter int TIME_W = TIME_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              run,
    input  logic              step_req,
    input  logic [CNT_W-1:0]  step_count,
    input  logic [DT_W-1:0]   dt_in,
    input  logic              stall,
    input  logic              stop_en,
    input  logic [TIME_W-1:0] stop_time,
    output logic              cke,
    output logic [DT_W-1:0]   dt_out,
    output logic [TIME_W-1:0] emu_time,
    output logic              busy,
    output logic              done,
    output logic              halted
);

    step_state_t      state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             cke_q, done_q, done_d, busy_q, halted_q;
    logic [DT_W-1:0]  dt_out_q, dt_out_d;
    logic             issue;
    logic             fits;

    emu_time_acc #(
        .DT_W   (DT_W),
        .TIME_W (TIME_W)
    ) u_acc (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .add_en    (issue),
        .dt_in     (dt_in),
        .stop_en   (stop_en),
        .stop_time (stop_time),
        .emu_time  (emu_time),
        .fits      (fits)
    );

    // remaining counts steps still owed by the burst; a stalled edge leaves it alone.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        issue       = 1'b0;
        done_d      = 1'b0;
        if (clr) begin
            state_d     = IDLE;
            remaining_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (run) begin
                        if (stall) begin
                            state_d = RUN;
                        end else if (fits) begin
                            state_d = RUN;
                            issue   = 1'b1;
                        end else begin
                            state_d = HALT;
                        end
                    end else if (step_req && (step_count != '0)) begin
                        if (stall) begin
                            state_d     = STEP;
                            remaining_d = step_count;
                        end else if (fits) begin
                            issue       = 1'b1;
                            remaining_d = step_count - CNT_W'(1);
                            if (step_count == CNT_W'(1)) begin
                                done_d  = 1'b1;
                                state_d = IDLE;
                            end else begin
                                state_d = STEP;
                            end
                        end else begin
                            state_d = HALT;
                        end
                    end
                end
                RUN: begin
                    if (!run) begin
                        state_d = IDLE;
                    end else if (!stall) begin
                        if (fits) begin
                            issue = 1'b1;
                        end else begin
                            state_d = HALT;
                        end
                    end
                end
                STEP: begin
                    if (!stall) begin
                        if (fits) begin
                            issue       = 1'b1;
                            remaining_d = remaining_q - CNT_W'(1);
                            if (remaining_q <= CNT_W'(1)) begin
                                done_d  = 1'b1;
                                state_d = IDLE;
                            end
                        end else begin
                            state_d     = HALT;
                            remaining_d = '0;
                        end
                    end
                end
                HALT: begin
                    state_d = HALT;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        dt_out_d = dt_out_q;
        if (issue) begin
            dt_out_d = dt_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
        end
    end

    // Status outputs reflect the state being entered so they line up with cke.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cke_q    <= 1'b0;
            dt_out_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            cke_q    <= issue;
            dt_out_q <= dt_out_d;
            done_q   <= done_d;
            busy_q   <= (state_d == RUN) || (state_d == STEP);
            halted_q <= (state_d == HALT);
        end
    end

    assign cke    = cke_q;
    assign dt_out = dt_out_q;
    assign done   = done_q;
    assign busy   = busy_q;
    assign halted = halted_q;

endmodule
